// File: rtl/uart_msg_sequencer_if.sv
// Byte handshake between the message sequencer and uart_tx.
// Master drives en/data, slave (uart_tx) answers with busy.
`timescale 1ns/1ps
interface uart_msg_sequencer_if #(
   parameter int PAYLOAD_BITS = 8
);
   logic                    tx_en;
   logic [PAYLOAD_BITS-1:0] tx_data;
   logic                    tx_busy;

   modport master (
      output tx_en,
      output tx_data,
      input  tx_busy
   );

   modport slave (
      input  tx_en,
      input  tx_data,
      output tx_busy
   );
endinterface

// File: rtl/uart_msg_sequencer.sv
// Sends one stored message, or a run of consecutive ones, byte by byte
// through the uart_tx en/busy handshake, skipping NUL padding if asked.
`timescale 1ns/1ps
module uart_msg_sequencer #(
   parameter int PAYLOAD_BITS = 8,
   parameter int MSG_BYTES    = 16,
   parameter int NUM_MSG      = 4,
   parameter int SKIP_NUL     = 1,
   localparam int SELW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1,
   localparam int BW   = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic                                  mode,
   input  logic [SELW-1:0]                       sel,
   input  logic [NUM_MSG*MSG_BYTES*PAYLOAD_BITS-1:0] msgs,
   uart_msg_sequencer_if.master                  tx,
   output logic                                  busy,
   output logic                                  done,
   output logic [SELW-1:0]                       msg_idx,
   output logic [BW-1:0]                         byte_idx
);

   localparam int S = MSG_BYTES * PAYLOAD_BITS;
   localparam logic [BW-1:0]   LAST_B = BW'(MSG_BYTES - 1);
   localparam logic [SELW-1:0] LAST_M = SELW'(NUM_MSG - 1);

   typedef enum logic [2:0] {
      IDLE, FETCH, SEND, ACK, DRAIN, NEXT, FIN
   } state_t;

   state_t                  state;
   state_t                  adv_state;
   logic                    mode_r;
   logic [1:0]              ack_cnt;
   logic [PAYLOAD_BITS-1:0] cur;
   logic [SELW-1:0]         adv_msg;
   logic [BW-1:0]           adv_byte;

   always_comb begin
      cur = msgs[int'(msg_idx)*S + int'(byte_idx)*PAYLOAD_BITS +: PAYLOAD_BITS];
   end

   // Walk step shared by NEXT and by a skipped NUL byte in FETCH.
   always_comb begin
      adv_state = FETCH;
      adv_msg   = msg_idx;
      adv_byte  = byte_idx - 1'b1;
      if (byte_idx == '0) begin
         if (mode_r && (msg_idx < LAST_M)) begin
            adv_msg  = msg_idx + 1'b1;
            adv_byte = LAST_B;
         end else begin
            adv_state = FIN;
            adv_byte  = byte_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         tx.tx_en   <= 1'b0;
         tx.tx_data <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         msg_idx    <= '0;
         byte_idx   <= LAST_B;
         mode_r     <= 1'b0;
         ack_cnt    <= '0;
      end else begin
         tx.tx_en <= 1'b0;
         done     <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  busy     <= 1'b1;
                  mode_r   <= mode;
                  byte_idx <= LAST_B;
                  if (int'(sel) >= NUM_MSG) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else begin
                     msg_idx <= sel;
                     state   <= FETCH;
                  end
               end
            end
            FETCH: begin
               if ((SKIP_NUL != 0) && (cur == '0)) begin
                  state    <= adv_state;
                  msg_idx  <= adv_msg;
                  byte_idx <= adv_byte;
                  done     <= (adv_state == FIN);
               end else if (!tx.tx_busy) begin
                  tx.tx_data <= cur;
                  tx.tx_en   <= 1'b1;
                  state      <= SEND;
               end
            end
            SEND: begin
               ack_cnt <= '0;
               state   <= ACK;
            end
            // A uart_tx that never raises busy still lets the walk proceed.
            ACK: begin
               if (tx.tx_busy) begin
                  state <= DRAIN;
               end else if (ack_cnt == 2'd3) begin
                  state <= NEXT;
               end else begin
                  ack_cnt <= ack_cnt + 1'b1;
               end
            end
            DRAIN: begin
               if (!tx.tx_busy) begin
                  state <= NEXT;
               end
            end
            NEXT: begin
               state    <= adv_state;
               msg_idx  <= adv_msg;
               byte_idx <= adv_byte;
               done     <= (adv_state == FIN);
            end
            FIN: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
